assoc_buffer_driver: RTL and testbench

ASSOC_BUFFER_DRIVER -- requirements
Module: assoc_buffer_driver

---
 rtl/assoc_buffer_driver.sv | 160 ++++++++++++++++
 tb/tb_assoc_buffer_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_buffer_driver.sv
// Sequencer that turns host requests into single-cycle associative-buffer commands and returns the sampled result.
// Optional statistics counters are built only when ASSOC_DRV_STATS_EN is defined.
module assoc_buffer_driver #(
    parameter int KEY_WIDTH    = 2,
    parameter int DATA_WIDTH   = 4,
    parameter int RESP_LATENCY = 1,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [KEY_WIDTH-1:0]  req_key,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic [1:0]            buf_ctrl,
    output logic [KEY_WIDTH-1:0]  buf_key,
    output logic [DATA_WIDTH-1:0] buf_data_input,
    input  logic [DATA_WIDTH-1:0] buf_data_output,
    input  logic                  buf_valid,
    output logic [STAT_WIDTH-1:0] stat_cmds,
    output logic [STAT_WIDTH-1:0] stat_hits
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [3:0] LAT_LOAD = 4'(RESP_LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_hit_q, resp_hit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            key_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_hit_q  <= resp_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_hit_d  = resp_hit_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    key_d  = req_key;
                    data_d = req_data;
                    // NONE never touches the buffer and answers a miss immediately
                    if (req_op == OP_NONE) begin
                        state_d     = S_RESP;
                        resp_data_d = '0;
                        resp_hit_d  = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    resp_data_d = buf_data_output;
                    resp_hit_d  = buf_valid;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_RESP);
    assign resp_data      = resp_data_q;
    assign resp_hit       = resp_hit_q;
    assign buf_ctrl       = (state_q == S_ISSUE) ? op_q : OP_NONE;
    assign buf_key        = key_q;
    assign buf_data_input = data_q;

`ifdef ASSOC_DRV_STATS_EN
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [STAT_WIDTH-1:0] cmds_q, cmds_d;
    logic [STAT_WIDTH-1:0] hits_q, hits_d;
    logic                  sample_hit;

    assign sample_hit = (state_q == S_WAIT) && (cnt_q == 4'd0) && buf_valid;

    always_comb begin
        cmds_d = cmds_q;
        hits_d = hits_q;
        if (state_q == S_ISSUE) begin
            cmds_d = sat_inc(cmds_q);
        end
        if (sample_hit) begin
            hits_d = sat_inc(hits_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmds_q <= '0;
            hits_q <= '0;
        end else begin
            cmds_q <= cmds_d;
            hits_q <= hits_d;
        end
    end

    assign stat_cmds = cmds_q;
    assign stat_hits = hits_q;
`else
    assign stat_cmds = '0;
    assign stat_hits = '0;
`endif

endmodule

// File: tb/tb_assoc_buffer_driver.sv
// Directed bench: a latency-1 driver talks to a small behavioural buffer, a latency-3 driver sees a hand-driven glitching result.
module tb_assoc_buffer_driver;

    localparam int KW = 2;
    localparam int DW = 4;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          req_valid, req_ready, resp_valid, resp_ready, resp_hit, buf_valid;
    logic [1:0]    req_op, buf_ctrl;
    logic [KW-1:0] req_key, buf_key;
    logic [DW-1:0] req_data, resp_data, buf_data_input, buf_data_output;
    logic [SW-1:0] stat_cmds, stat_hits;

    logic          b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_hit, b_buf_valid;
    logic [1:0]    b_req_op, b_buf_ctrl;
    logic [KW-1:0] b_req_key, b_buf_key;
    logic [DW-1:0] b_req_data, b_resp_data, b_buf_data_input, b_buf_data_output;
    logic [SW-1:0] b_stat_cmds, b_stat_hits;

    int checks = 0;
    int errors = 0;

    assoc_buffer_driver #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .RESP_LATENCY(1), .STAT_WIDTH(SW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_hit(resp_hit),
        .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data_input(buf_data_input),
        .buf_data_output(buf_data_output), .buf_valid(buf_valid),
        .stat_cmds(stat_cmds), .stat_hits(stat_hits)
    );

    assoc_buffer_driver #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .RESP_LATENCY(3), .STAT_WIDTH(SW)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .req_key(b_req_key), .req_data(b_req_data),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_data(b_resp_data), .resp_hit(b_resp_hit),
        .buf_ctrl(b_buf_ctrl), .buf_key(b_buf_key), .buf_data_input(b_buf_data_input),
        .buf_data_output(b_buf_data_output), .buf_valid(b_buf_valid),
        .stat_cmds(b_stat_cmds), .stat_hits(b_stat_hits)
    );

    // Behavioural associative buffer: result is ready one edge after the command
    logic [DW-1:0] mem [4];
    logic          mvld [4];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i]  <= '0;
                mvld[i] <= 1'b0;
            end
            buf_data_output <= '0;
            buf_valid       <= 1'b0;
        end else begin
            case (buf_ctrl)
                2'd1: begin
                    buf_data_output <= mem[buf_key];
                    buf_valid       <= mvld[buf_key];
                end
                2'd2: begin
                    mem[buf_key]    <= buf_data_input;
                    mvld[buf_key]   <= 1'b1;
                    buf_data_output <= '0;
                    buf_valid       <= 1'b0;
                end
                2'd3: begin
                    if (mvld[buf_key]) begin
                        mem[buf_key]    <= mem[buf_key] + 1'b1;
                        buf_data_output <= mem[buf_key] + 1'b1;
                        buf_valid       <= 1'b1;
                    end else begin
                        buf_data_output <= '0;
                        buf_valid       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the latency-1 instance; returns what was observed
    task automatic run_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data,
                           input int hold, output int lat, output int nissue,
                           output logic [1:0] ictrl, output logic [KW-1:0] ikey,
                           output logic [DW-1:0] idata, output logic [DW-1:0] rdata,
                           output logic rhit);
        ictrl = '0; ikey = '0; idata = '0;
        req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
        tick();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_key   = KW'($urandom);
        req_data  = DW'($urandom);
        lat = 0;
        nissue = 0;
        while (!resp_valid && lat < 20) begin
            if (buf_ctrl != 2'd0) begin
                nissue++;
                ictrl = buf_ctrl;
                ikey  = buf_key;
                idata = buf_data_input;
            end
            tick();
            lat++;
        end
        rdata = resp_data;
        rhit  = resp_hit;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 2'd2;
            tick();
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_buf_ctrl", 32'(buf_ctrl), 32'd0);
            check("hold_resp_data", 32'(resp_data), 32'(rdata));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("ret_resp_valid", 32'(resp_valid), 32'd0);
        check("ret_req_ready", 32'(req_ready), 32'd1);
    endtask

    int            lat, nissue;
    logic [1:0]    ictrl;
    logic [KW-1:0] ikey;
    logic [DW-1:0] idata, rdata;
    logic          rhit;
    int            exp_cmds, exp_hits;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0; resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_op = '0; b_req_key = '0; b_req_data = '0; b_resp_ready = 1'b0;
        b_buf_data_output = '0; b_buf_valid = 1'b0;
        tick();
        tick();
        check("rst_buf_ctrl", 32'(buf_ctrl), 32'd0);
        check("rst_buf_key", 32'(buf_key), 32'd0);
        check("rst_buf_data_input", 32'(buf_data_input), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_hit", 32'(resp_hit), 32'd0);
        check("rst_stat_cmds", 32'(stat_cmds), 32'd0);
        check("rst_stat_hits", 32'(stat_hits), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_b_req_ready", 32'(b_req_ready), 32'd1);

        // LOAD key 1 data E
        run_req(2'd2, 2'd1, 4'hE, 0, lat, nissue, ictrl, ikey, idata, rdata, rhit);
        check("load_latency", 32'(lat), 32'd2);
        check("load_issue_cycles", 32'(nissue), 32'd1);
        check("load_buf_ctrl", 32'(ictrl), 32'd2);
        check("load_buf_key", 32'(ikey), 32'd1);
        check("load_buf_data", 32'(idata), 32'hE);

        // SEARCH key 1 finds E
        run_req(2'd1, 2'd1, 4'h0, 0, lat, nissue, ictrl, ikey, idata, rdata, rhit);
        check("search_latency", 32'(lat), 32'd2);
        check("search_buf_ctrl", 32'(ictrl), 32'd1);
        check("search_data", 32'(rdata), 32'hE);
        check("search_hit", 32'(rhit), 32'd1);
`ifdef ASSOC_DRV_STATS_EN
        exp_cmds = 2; exp_hits = 1;
`else
        exp_cmds = 0; exp_hits = 0;
`endif
        check("search_stat_cmds", 32'(stat_cmds), 32'(exp_cmds));
        check("search_stat_hits", 32'(stat_hits), 32'(exp_hits));

        // INCR key 1 returns F while the host stalls the response
        run_req(2'd3, 2'd1, 4'h0, 5, lat, nissue, ictrl, ikey, idata, rdata, rhit);
        check("incr_buf_ctrl", 32'(ictrl), 32'd3);
        check("incr_data", 32'(rdata), 32'hF);
        check("incr_hit", 32'(rhit), 32'd1);

        // SEARCH of a key never loaded misses
        run_req(2'd1, 2'd2, 4'h0, 0, lat, nissue, ictrl, ikey, idata, rdata, rhit);
        check("miss_hit", 32'(rhit), 32'd0);
        check("miss_data", 32'(rdata), 32'd0);

        // NONE answers one cycle after acceptance without a buffer command
        run_req(2'd0, 2'd3, 4'h7, 1, lat, nissue, ictrl, ikey, idata, rdata, rhit);
        check("none_latency", 32'(lat), 32'd0);
        check("none_issue_cycles", 32'(nissue), 32'd0);
        check("none_data", 32'(rdata), 32'd0);
        check("none_hit", 32'(rhit), 32'd0);
        check("none_buf_key_held", 32'(buf_key), 32'd3);
        check("none_buf_data_held", 32'(buf_data_input), 32'd7);
`ifdef ASSOC_DRV_STATS_EN
        exp_cmds = 4; exp_hits = 2;
`else
        exp_cmds = 0; exp_hits = 0;
`endif
        check("none_stat_cmds", 32'(stat_cmds), 32'(exp_cmds));
        check("none_stat_hits", 32'(stat_hits), 32'(exp_hits));

        // Latency-3 instance: only the value present at the final WAIT edge is captured
        b_req_valid = 1'b1; b_req_op = 2'd1; b_req_key = 2'd2; b_req_data = 4'h6;
        tick();
        b_req_valid = 1'b0; b_req_key = 2'd0; b_req_data = 4'h0;
        check("l3_issue_ctrl", 32'(b_buf_ctrl), 32'd1);
        check("l3_issue_key", 32'(b_buf_key), 32'd2);
        check("l3_issue_data", 32'(b_buf_data_input), 32'h6);
        b_buf_data_output = 4'h5; b_buf_valid = 1'b1;
        tick();
        check("l3_wait_ctrl", 32'(b_buf_ctrl), 32'd0);
        check("l3_wait1_valid", 32'(b_resp_valid), 32'd0);
        b_buf_data_output = 4'h9; b_buf_valid = 1'b0;
        tick();
        check("l3_wait2_valid", 32'(b_resp_valid), 32'd0);
        b_buf_data_output = 4'h3; b_buf_valid = 1'b1;
        tick();
        check("l3_wait3_valid", 32'(b_resp_valid), 32'd0);
        tick();
        check("l3_resp_valid", 32'(b_resp_valid), 32'd1);
        check("l3_resp_data", 32'(b_resp_data), 32'h3);
        check("l3_resp_hit", 32'(b_resp_hit), 32'd1);
        b_buf_data_output = 4'h7; b_buf_valid = 1'b0;
        tick();
        check("l3_hold_data", 32'(b_resp_data), 32'h3);
        check("l3_hold_hit", 32'(b_resp_hit), 32'd1);
`ifdef ASSOC_DRV_STATS_EN
        exp_cmds = 1; exp_hits = 1;
`else
        exp_cmds = 0; exp_hits = 0;
`endif
        check("l3_stat_cmds", 32'(b_stat_cmds), 32'(exp_cmds));
        check("l3_stat_hits", 32'(b_stat_hits), 32'(exp_hits));
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        check("l3_ret_ready", 32'(b_req_ready), 32'd1);

        // Reset while WAITing abandons the request
        req_valid = 1'b1; req_op = 2'd1; req_key = 2'd1; req_data = 4'h0;
        tick();
        req_valid = 1'b0;
        tick();
        check("abort_pre_valid", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_buf_ctrl", 32'(buf_ctrl), 32'd0);
        check("abort_buf_key", 32'(buf_key), 32'd0);
        check("abort_stat_cmds", 32'(stat_cmds), 32'd0);
        check("abort_stat_hits", 32'(stat_hits), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            check("abort_ctrl_idle", 32'(buf_ctrl), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
